proc_ctrl: RTL and testbench

- Pipelined control unit for the five-stage TinyRV1 processor (F/D/X/M/W).
- Decodes the instruction held in D and carries per-stage control bits down the pipeline.
- Detects hazards and drives every c2d_* select/enable of the datapath.
- Consumes the datapath status outputs d2c_inst and d2c_eq_X.

---
 rtl/proc_ctrl_if.sv | 39 +++
 rtl/proc_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_proc_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/proc_ctrl_if.sv
// proc_ctrl_if: control <-> datapath signal bundle of the TinyRV1 five-stage pipeline.
// master = control unit (drives c2d_*), slave = datapath (drives d2c_*).
interface proc_ctrl_if;
   logic [31:0] d2c_inst;
   logic        d2c_eq_X;

   logic        c2d_imemreq_val_F;
   logic        c2d_reg_en_F;
   logic [1:0]  c2d_pc_sel_F;
   logic        c2d_reg_en_D;
   logic [1:0]  c2d_imm_type_D;
   logic [1:0]  c2d_op1_byp_sel_D;
   logic [1:0]  c2d_op2_byp_sel_D;
   logic        c2d_op1_sel_D;
   logic [1:0]  c2d_op2_sel_D;
   logic        c2d_alu_fn_X;
   logic        c2d_result_sel_X;
   logic        c2d_dmemreq_val_M;
   logic        c2d_dmemreq_type_M;
   logic        c2d_wb_sel_M;
   logic        c2d_rf_wen_W;
   logic [4:0]  c2d_rf_waddr_W;

   modport master (
      input  d2c_inst, d2c_eq_X,
      output c2d_imemreq_val_F, c2d_reg_en_F, c2d_pc_sel_F, c2d_reg_en_D,
             c2d_imm_type_D, c2d_op1_byp_sel_D, c2d_op2_byp_sel_D, c2d_op1_sel_D,
             c2d_op2_sel_D, c2d_alu_fn_X, c2d_result_sel_X, c2d_dmemreq_val_M,
             c2d_dmemreq_type_M, c2d_wb_sel_M, c2d_rf_wen_W, c2d_rf_waddr_W
   );

   modport slave (
      output d2c_inst, d2c_eq_X,
      input  c2d_imemreq_val_F, c2d_reg_en_F, c2d_pc_sel_F, c2d_reg_en_D,
             c2d_imm_type_D, c2d_op1_byp_sel_D, c2d_op2_byp_sel_D, c2d_op1_sel_D,
             c2d_op2_sel_D, c2d_alu_fn_X, c2d_result_sel_X, c2d_dmemreq_val_M,
             c2d_dmemreq_type_M, c2d_wb_sel_M, c2d_rf_wen_W, c2d_rf_waddr_W
   );
endinterface

// File: rtl/proc_ctrl.sv
// proc_ctrl: pipelined F/D/X/M/W control unit for TinyRV1 (decode, bypass, stall, squash).
// Define PROC_CTRL_BNE_EN to add bne with branch resolution in X.
module proc_ctrl (
   input  logic        clk,
   input  logic        rst,
   proc_ctrl_if.master bus
);
   localparam logic [6:0] OP_RR   = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_BR   = 7'b1100011;

   typedef struct packed {
      logic       val;
      logic [4:0] rd;
      logic       rf_wen;
      logic       is_load;
      logic       alu_fn;
      logic       result_sel;
      logic       dmem_val;
      logic       dmem_type;
      logic       wb_sel;
      logic       is_branch;
   } x_t;

   typedef struct packed {
      logic       val;
      logic [4:0] rd;
      logic       rf_wen;
      logic       dmem_val;
      logic       dmem_type;
      logic       wb_sel;
   } m_t;

   typedef struct packed {
      logic       val;
      logic [4:0] rd;
      logic       rf_wen;
   } w_t;

   logic val_D_q, val_D_d;
   x_t   x_q, x_d;
   m_t   m_q, m_d;
   w_t   w_q, w_d;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [4:0] rd_D, rs1_D, rs2_D;

   assign opcode = bus.d2c_inst[6:0];
   assign rd_D   = bus.d2c_inst[11:7];
   assign funct3 = bus.d2c_inst[14:12];
   assign rs1_D  = bus.d2c_inst[19:15];
   assign rs2_D  = bus.d2c_inst[24:20];
   assign funct7 = bus.d2c_inst[31:25];

   logic       dec_known, dec_rs1_use, dec_rs2_use, dec_rf_wen, dec_is_load;
   logic       dec_alu_fn, dec_result_sel, dec_dmem_val, dec_dmem_type, dec_wb_sel;
   logic       dec_is_branch, dec_jal, dec_jr, dec_op1_sel;
   logic [1:0] dec_imm_type, dec_op2_sel;

   always_comb begin
      dec_known      = 1'b0;
      dec_rs1_use    = 1'b0;
      dec_rs2_use    = 1'b0;
      dec_rf_wen     = 1'b0;
      dec_is_load    = 1'b0;
      dec_alu_fn     = 1'b0;
      dec_result_sel = 1'b0;
      dec_dmem_val   = 1'b0;
      dec_dmem_type  = 1'b0;
      dec_wb_sel     = 1'b0;
      dec_is_branch  = 1'b0;
      dec_jal        = 1'b0;
      dec_jr         = 1'b0;
      dec_op1_sel    = 1'b0;
      dec_imm_type   = 2'd0;
      dec_op2_sel    = 2'd0;
      case (opcode)
         OP_RR: begin
            if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0000001)) begin
               dec_known      = 1'b1;
               dec_rs1_use    = 1'b1;
               dec_rs2_use    = 1'b1;
               dec_rf_wen     = 1'b1;
               dec_result_sel = funct7[0];
            end
         end
         OP_ADDI: begin
            if (funct3 == 3'b000) begin
               dec_known   = 1'b1;
               dec_rs1_use = 1'b1;
               dec_rf_wen  = 1'b1;
               dec_op2_sel = 2'd1;
            end
         end
         OP_LW: begin
            if (funct3 == 3'b010) begin
               dec_known    = 1'b1;
               dec_rs1_use  = 1'b1;
               dec_rf_wen   = 1'b1;
               dec_is_load  = 1'b1;
               dec_op2_sel  = 2'd1;
               dec_dmem_val = 1'b1;
               dec_wb_sel   = 1'b1;
            end
         end
         OP_SW: begin
            // rs2 is the store data and still goes through the op2 bypass mux
            if (funct3 == 3'b010) begin
               dec_known     = 1'b1;
               dec_rs1_use   = 1'b1;
               dec_rs2_use   = 1'b1;
               dec_imm_type  = 2'd1;
               dec_op2_sel   = 2'd1;
               dec_dmem_val  = 1'b1;
               dec_dmem_type = 1'b1;
            end
         end
         OP_JAL: begin
            dec_known    = 1'b1;
            dec_jal      = 1'b1;
            dec_rf_wen   = 1'b1;
            dec_imm_type = 2'd2;
            dec_op1_sel  = 1'b1;
            dec_op2_sel  = 2'd2;
         end
         OP_JALR: begin
            if (funct3 == 3'b000) begin
               dec_known   = 1'b1;
               dec_jr      = 1'b1;
               dec_rs1_use = 1'b1;
            end
         end
`ifdef PROC_CTRL_BNE_EN
         OP_BR: begin
            if (funct3 == 3'b001) begin
               dec_known     = 1'b1;
               dec_rs1_use   = 1'b1;
               dec_rs2_use   = 1'b1;
               dec_imm_type  = 2'd3;
               dec_alu_fn    = 1'b1;
               dec_is_branch = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   logic d_val, rs1_use, rs2_use, stall, br_taken, redir_D, squash;

   assign d_val   = val_D_q & dec_known;
   assign rs1_use = d_val & dec_rs1_use;
   assign rs2_use = d_val & dec_rs2_use;

   assign stall = x_q.val & x_q.is_load & x_q.rf_wen &
                  ((rs1_use & (rs1_D == x_q.rd)) | (rs2_use & (rs2_D == x_q.rd)));

`ifdef PROC_CTRL_BNE_EN
   assign br_taken = x_q.val & x_q.is_branch & ~bus.d2c_eq_X;
`else
   logic unused_br;
   assign unused_br = x_q.is_branch ^ bus.d2c_eq_X ^ OP_BR[0];
   assign br_taken  = 1'b0;
`endif

   assign redir_D = d_val & (dec_jal | dec_jr) & ~stall;
   assign squash  = br_taken | redir_D;

   function automatic logic [1:0] byp_sel(input logic used, input logic [4:0] rs,
                                          input x_t x, input m_t m, input w_t w);
      if (!used || rs == 5'd0)                 return 2'd0;
      if (x.val && x.rf_wen && x.rd == rs)     return 2'd1;
      if (m.val && m.rf_wen && m.rd == rs)     return 2'd2;
      if (w.val && w.rf_wen && w.rd == rs)     return 2'd3;
      return 2'd0;
   endfunction

   always_comb begin
      val_D_d = squash ? 1'b0 : (stall ? val_D_q : 1'b1);

      x_d            = '0;
      x_d.val        = d_val & ~stall & ~br_taken;
      x_d.rd         = rd_D;
      x_d.rf_wen     = dec_rf_wen & (rd_D != 5'd0);
      x_d.is_load    = dec_is_load;
      x_d.alu_fn     = dec_alu_fn;
      x_d.result_sel = dec_result_sel;
      x_d.dmem_val   = dec_dmem_val;
      x_d.dmem_type  = dec_dmem_type;
      x_d.wb_sel     = dec_wb_sel;
      x_d.is_branch  = dec_is_branch;

      m_d = '{val: x_q.val, rd: x_q.rd, rf_wen: x_q.rf_wen, dmem_val: x_q.dmem_val,
              dmem_type: x_q.dmem_type, wb_sel: x_q.wb_sel};
      w_d = '{val: m_q.val, rd: m_q.rd, rf_wen: m_q.rf_wen};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_D_q <= 1'b0;
         x_q     <= '0;
         m_q     <= '0;
         w_q     <= '0;
      end else begin
         val_D_q <= val_D_d;
         x_q     <= x_d;
         m_q     <= m_d;
         w_q     <= w_d;
      end
   end

   assign bus.c2d_imemreq_val_F  = ~rst;
   assign bus.c2d_reg_en_F       = ~rst & ~stall;
   assign bus.c2d_reg_en_D       = ~rst & ~stall;
   assign bus.c2d_pc_sel_F       = br_taken ? 2'd3 : (redir_D ? (dec_jal ? 2'd2 : 2'd1) : 2'd0);

   assign bus.c2d_imm_type_D     = d_val ? dec_imm_type : 2'd0;
   assign bus.c2d_op1_sel_D      = d_val & dec_op1_sel;
   assign bus.c2d_op2_sel_D      = d_val ? dec_op2_sel : 2'd0;
   assign bus.c2d_op1_byp_sel_D  = byp_sel(rs1_use, rs1_D, x_q, m_q, w_q);
   assign bus.c2d_op2_byp_sel_D  = byp_sel(rs2_use, rs2_D, x_q, m_q, w_q);

   assign bus.c2d_alu_fn_X       = x_q.val & x_q.alu_fn;
   assign bus.c2d_result_sel_X   = x_q.val & x_q.result_sel;
   assign bus.c2d_dmemreq_val_M  = m_q.val & m_q.dmem_val;
   assign bus.c2d_dmemreq_type_M = m_q.val & m_q.dmem_type;
   assign bus.c2d_wb_sel_M       = m_q.val & m_q.wb_sel;
   assign bus.c2d_rf_wen_W       = w_q.val & w_q.rf_wen;
   assign bus.c2d_rf_waddr_W     = w_q.val ? w_q.rd : 5'd0;
endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: directed-vector bench for proc_ctrl; the bench plays the datapath,
// presenting the instruction in D each cycle and checking control outputs mid-cycle.
module tb_proc_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nmis = 0;

   proc_ctrl_if bus ();
   proc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

`ifdef PROC_CTRL_BNE_EN
   localparam bit BNE = 1'b1;
`else
   localparam bit BNE = 1'b0;
`endif

   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic [31:0] e_addi(input int rd, input int rs1, input int imm);
      logic [11:0] i = imm[11:0];
      return {i, rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
   endfunction
   function automatic logic [31:0] e_rr(input int f7, input int rd, input int rs1, input int rs2);
      return {f7[6:0], rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
   endfunction
   function automatic logic [31:0] e_lw(input int rd, input int rs1, input int imm);
      logic [11:0] i = imm[11:0];
      return {i, rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
   endfunction
   function automatic logic [31:0] e_sw(input int rs2, input int rs1, input int imm);
      logic [11:0] i = imm[11:0];
      return {i[11:5], rs2[4:0], rs1[4:0], 3'b010, i[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] e_jal(input int rd, input int imm);
      logic [20:0] i = imm[20:0];
      return {i[20], i[10:1], i[11], i[19:12], rd[4:0], 7'b1101111};
   endfunction
   function automatic logic [31:0] e_jr(input int rs1);
      return {12'd0, rs1[4:0], 3'b000, 5'd0, 7'b1100111};
   endfunction
   function automatic logic [31:0] e_bne(input int rs1, input int rs2, input int imm);
      logic [12:0] i = imm[12:0];
      return {i[12], i[10:5], rs2[4:0], rs1[4:0], 3'b001, i[4:1], i[11], 7'b1100011};
   endfunction

   task automatic step(input logic [31:0] inst, input logic eq);
      @(negedge clk);
      bus.d2c_inst = inst;
      bus.d2c_eq_X = eq;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.d2c_inst = NOP;
      bus.d2c_eq_X = 1'b1;

      for (int i = 0; i < 3; i++) begin
         step(NOP, 1'b1);
         chk("rst_imemval", bus.c2d_imemreq_val_F, 0);
         chk("rst_regenF", bus.c2d_reg_en_F, 0);
         chk("rst_rfwenW", bus.c2d_rf_wen_W, 0);
         chk("rst_dmemval", bus.c2d_dmemreq_val_M, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_imemval", bus.c2d_imemreq_val_F, 1);
      chk("rel_regenF", bus.c2d_reg_en_F, 1);
      chk("rel_rfwenW", bus.c2d_rf_wen_W, 0);
      chk("rel_op2sel_valD0", bus.c2d_op2_sel_D, 0);

      // bypass chain
      step(e_addi(1, 0, 5), 1'b1);
      chk("addi_op2sel", bus.c2d_op2_sel_D, 1);
      chk("addi_imm", bus.c2d_imm_type_D, 0);
      chk("addi_byp1", bus.c2d_op1_byp_sel_D, 0);
      step(e_rr(0, 2, 1, 1), 1'b1);
      chk("add2_byp1", bus.c2d_op1_byp_sel_D, 1);
      chk("add2_byp2", bus.c2d_op2_byp_sel_D, 1);
      chk("add2_op2sel", bus.c2d_op2_sel_D, 0);
      step(e_rr(0, 3, 2, 1), 1'b1);
      chk("add3_byp1", bus.c2d_op1_byp_sel_D, 1);
      chk("add3_byp2", bus.c2d_op2_byp_sel_D, 2);
      chk("add3_regenF", bus.c2d_reg_en_F, 1);
      step(NOP, 1'b1);
      chk("w_addi_wen", bus.c2d_rf_wen_W, 1);
      chk("w_addi_addr", bus.c2d_rf_waddr_W, 1);
      step(NOP, 1'b1);
      chk("w_add2_addr", bus.c2d_rf_waddr_W, 2);
      step(NOP, 1'b1);
      chk("w_add3_wen", bus.c2d_rf_wen_W, 1);
      chk("w_add3_addr", bus.c2d_rf_waddr_W, 3);

      // load-use
      step(e_lw(4, 0, 0), 1'b1);
      chk("lw_op2sel", bus.c2d_op2_sel_D, 1);
      chk("lw_regenF", bus.c2d_reg_en_F, 1);
      step(e_rr(0, 5, 4, 4), 1'b1);
      chk("stall_regenF", bus.c2d_reg_en_F, 0);
      chk("stall_regenD", bus.c2d_reg_en_D, 0);
      chk("stall_pcsel", bus.c2d_pc_sel_F, 0);
      step(e_rr(0, 5, 4, 4), 1'b1);
      chk("post_regenF", bus.c2d_reg_en_F, 1);
      chk("post_regenD", bus.c2d_reg_en_D, 1);
      chk("post_byp1", bus.c2d_op1_byp_sel_D, 2);
      chk("post_byp2", bus.c2d_op2_byp_sel_D, 2);
      chk("lwM_dmemval", bus.c2d_dmemreq_val_M, 1);
      chk("lwM_type", bus.c2d_dmemreq_type_M, 0);
      chk("lwM_wbsel", bus.c2d_wb_sel_M, 1);
      step(e_rr(0, 6, 1, 1), 1'b1);
      chk("indep_regenF", bus.c2d_reg_en_F, 1);
      chk("indep_byp1", bus.c2d_op1_byp_sel_D, 0);
      chk("bubbleM_dmemval", bus.c2d_dmemreq_val_M, 0);
      chk("lwW_addr", bus.c2d_rf_waddr_W, 4);
      step(NOP, 1'b1);
      chk("bubbleW_wen", bus.c2d_rf_wen_W, 0);

      // jal / jr
      step(e_jal(1, 8), 1'b1);
      chk("jal_pcsel", bus.c2d_pc_sel_F, 2);
      chk("jal_op1sel", bus.c2d_op1_sel_D, 1);
      chk("jal_op2sel", bus.c2d_op2_sel_D, 2);
      chk("jal_imm", bus.c2d_imm_type_D, 2);
      step(e_rr(0, 7, 1, 1), 1'b1);
      chk("sq204_byp1", bus.c2d_op1_byp_sel_D, 0);
      chk("sq204_pcsel", bus.c2d_pc_sel_F, 0);
      step(e_addi(1, 0, 12'h300), 1'b1);
      chk("tgt_op2sel", bus.c2d_op2_sel_D, 1);
      step(e_jr(1), 1'b1);
      chk("jr_byp1", bus.c2d_op1_byp_sel_D, 1);
      chk("jr_pcsel", bus.c2d_pc_sel_F, 1);
      chk("jr_op1sel", bus.c2d_op1_sel_D, 0);
      chk("jalW_wen", bus.c2d_rf_wen_W, 1);
      chk("jalW_addr", bus.c2d_rf_waddr_W, 1);
      step(e_rr(0, 8, 1, 1), 1'b1);
      chk("sqjr_byp1", bus.c2d_op1_byp_sel_D, 0);
      chk("sqjr_pcsel", bus.c2d_pc_sel_F, 0);
      chk("sq204W_wen", bus.c2d_rf_wen_W, 0);

      // store, x0 destination, mul
      step(e_sw(2, 0, 4), 1'b1);
      chk("sw_imm", bus.c2d_imm_type_D, 1);
      chk("sw_op2sel", bus.c2d_op2_sel_D, 1);
      chk("sw_byp2", bus.c2d_op2_byp_sel_D, 0);
      step(e_addi(0, 0, 7), 1'b1);
      step(e_rr(1, 9, 1, 1), 1'b1);
      chk("swM_dmemval", bus.c2d_dmemreq_val_M, 1);
      chk("swM_type", bus.c2d_dmemreq_type_M, 1);
      chk("swM_wbsel", bus.c2d_wb_sel_M, 0);
      chk("addiX_rsel", bus.c2d_result_sel_X, 0);
      step(NOP, 1'b1);
      chk("mulX_rsel", bus.c2d_result_sel_X, 1);
      chk("swW_wen", bus.c2d_rf_wen_W, 0);
      chk("x0M_dmemval", bus.c2d_dmemreq_val_M, 0);
      step(NOP, 1'b1);
      chk("x0W_wen", bus.c2d_rf_wen_W, 0);
      step(NOP, 1'b1);
      chk("mulW_wen", bus.c2d_rf_wen_W, 1);
      chk("mulW_addr", bus.c2d_rf_waddr_W, 9);

      // bne taken
      step(e_bne(1, 2, 16), 1'b1);
      chk("bne_imm", bus.c2d_imm_type_D, BNE ? 3 : 0);
      chk("bne_op2sel", bus.c2d_op2_sel_D, 0);
      step(e_rr(0, 10, 0, 0), 1'b0);
      chk("bneT_pcsel", bus.c2d_pc_sel_F, BNE ? 3 : 0);
      chk("bneT_alufn", bus.c2d_alu_fn_X, BNE ? 1 : 0);
      chk("bneT_regenF", bus.c2d_reg_en_F, 1);
      step(e_rr(0, 11, 0, 0), 1'b1);
      chk("bneT_pcsel2", bus.c2d_pc_sel_F, 0);
      step(e_rr(0, 12, 0, 0), 1'b1);
      step(NOP, 1'b1);
      chk("sq1W_wen", bus.c2d_rf_wen_W, BNE ? 0 : 1);
      chk("sq1W_addr", bus.c2d_rf_waddr_W, BNE ? 0 : 10);
      step(NOP, 1'b1);
      chk("sq2W_wen", bus.c2d_rf_wen_W, BNE ? 0 : 1);
      chk("sq2W_addr", bus.c2d_rf_waddr_W, BNE ? 0 : 11);
      step(NOP, 1'b1);
      chk("tgtW_wen", bus.c2d_rf_wen_W, 1);
      chk("tgtW_addr", bus.c2d_rf_waddr_W, 12);

      // bne not taken
      step(e_bne(1, 1, 16), 1'b1);
      step(e_rr(0, 13, 0, 0), 1'b1);
      chk("bneN_pcsel", bus.c2d_pc_sel_F, 0);
      chk("bneN_alufn", bus.c2d_alu_fn_X, BNE ? 1 : 0);
      step(e_rr(0, 14, 0, 0), 1'b1);
      step(NOP, 1'b1);
      step(NOP, 1'b1);
      chk("nt1W_addr", bus.c2d_rf_waddr_W, 13);
      chk("nt1W_wen", bus.c2d_rf_wen_W, 1);
      step(e_addi(5, 0, 1), 1'b1);
      chk("nt2W_addr", bus.c2d_rf_waddr_W, 14);

      // asynchronous reset with a store in M and a writeback in W
      step(e_sw(0, 0, 0), 1'b1);
      step(NOP, 1'b1);
      step(NOP, 1'b1);
      chk("pre_dmemval", bus.c2d_dmemreq_val_M, 1);
      chk("pre_rfwen", bus.c2d_rf_wen_W, 1);
      chk("pre_addr", bus.c2d_rf_waddr_W, 5);
      #2 rst = 1'b1;
      #1;
      chk("arst_dmemval", bus.c2d_dmemreq_val_M, 0);
      chk("arst_rfwen", bus.c2d_rf_wen_W, 0);
      chk("arst_imemval", bus.c2d_imemreq_val_F, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arel_imemval", bus.c2d_imemreq_val_F, 1);
      chk("arel_rfwen", bus.c2d_rf_wen_W, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
